// File: rtl/uart_frame_assembler.sv
// Packs a UART byte stream into words (MSB-first) and words into frames,
// presented on a valid/ready output with overflow, idle-timeout and abort handling.
//
// state    | meaning
// ST_IDLE  | no partial frame; next byte starts a frame and latches its length
// ST_ASM   | partial frame in progress; idle timer running between bytes
module uart_frame_assembler #(
  parameter int WORD_W      = 32,
  parameter int MAX_WORDS   = 4,
  parameter int TIMEOUT_CYC = 40000,
  parameter int TO_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sync_clr,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_byte_en,
  input  logic [3:0]                    frame_words,
  output logic [MAX_WORDS*WORD_W-1:0]   frame_data,
  output logic [3:0]                    frame_nwords,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [3:0]                    word_cnt,
  output logic                          busy,
  output logic                          overflow,
  output logic                          timeout_err
);

  localparam int        BPW       = WORD_W / 8;
  localparam int        FW        = MAX_WORDS * WORD_W;
  localparam logic [3:0] MAXW     = 4'(MAX_WORDS);
  localparam logic [3:0] BYTE_LAST = 4'(BPW - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic {ST_IDLE, ST_ASM} state_t;

  state_t            state_q, state_d;
  logic [3:0]        byte_cnt_q, byte_cnt_d;
  logic [3:0]        word_cnt_q, word_cnt_d;
  logic [3:0]        nwords_q, nwords_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic [WORD_W-1:0] word_sr_q, word_sr_d;
  logic [FW-1:0]     frame_sr_q, frame_sr_d;
  logic [FW-1:0]     frame_data_q, frame_data_d;
  logic [3:0]        frame_nwords_q, frame_nwords_d;
  logic              frame_valid_q, frame_valid_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;

  logic [3:0]           req_len, n_eff;
  logic [FW-1:0]        frame_base;
  logic [WORD_W+7:0]    word_cat;
  logic [WORD_W-1:0]    word_nxt;
  logic [FW+WORD_W-1:0] frame_cat;
  logic                 discard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      byte_cnt_q     <= '0;
      word_cnt_q     <= '0;
      nwords_q       <= '0;
      idle_q         <= '0;
      word_sr_q      <= '0;
      frame_sr_q     <= '0;
      frame_data_q   <= '0;
      frame_nwords_q <= '0;
      frame_valid_q  <= 1'b0;
      overflow_q     <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      word_cnt_q     <= word_cnt_d;
      nwords_q       <= nwords_d;
      idle_q         <= idle_d;
      word_sr_q      <= word_sr_d;
      frame_sr_q     <= frame_sr_d;
      frame_data_q   <= frame_data_d;
      frame_nwords_q <= frame_nwords_d;
      frame_valid_q  <= frame_valid_d;
      overflow_q     <= overflow_d;
      timeout_q      <= timeout_d;
    end
  end

  // Out-of-range requested lengths fall back to the largest frame.
  assign req_len = (frame_words == 4'd0 || frame_words > MAXW) ? MAXW : frame_words;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    word_cnt_d     = word_cnt_q;
    nwords_d       = nwords_q;
    idle_d         = idle_q;
    word_sr_d      = word_sr_q;
    frame_sr_d     = frame_sr_q;
    frame_data_d   = frame_data_q;
    frame_nwords_d = frame_nwords_q;
    frame_valid_d  = frame_valid_q & ~frame_ready;
    overflow_d     = 1'b0;
    timeout_d      = 1'b0;
    discard        = 1'b0;
    n_eff          = (state_q == ST_IDLE) ? req_len : nwords_q;
    frame_base     = (state_q == ST_IDLE) ? '0 : frame_sr_q;
    word_cat       = {word_sr_q, rx_byte};
    word_nxt       = word_cat[WORD_W-1:0];
    frame_cat      = {frame_base, word_nxt};

    if (sync_clr) begin
      discard = 1'b1;
    end else if (rx_byte_en) begin
      state_d  = ST_ASM;
      idle_d   = '0;
      nwords_d = n_eff;
      if (byte_cnt_q != BYTE_LAST) begin
        byte_cnt_d = byte_cnt_q + 4'd1;
        word_sr_d  = word_nxt;
        frame_sr_d = frame_base;
      end else if ((word_cnt_q + 4'd1) != n_eff) begin
        byte_cnt_d = '0;
        word_sr_d  = '0;
        word_cnt_d = word_cnt_q + 4'd1;
        frame_sr_d = frame_cat[FW-1:0];
      end else begin
        discard = 1'b1;
        // A held, unaccepted frame wins over the new one.
        if (!frame_valid_q || frame_ready) begin
          frame_data_d   = frame_cat[FW-1:0];
          frame_nwords_d = n_eff;
          frame_valid_d  = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end else if (state_q == ST_ASM) begin
      if (idle_q == TO_LAST) begin
        discard   = 1'b1;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + TO_W'(1);
      end
    end

    if (discard) begin
      state_d    = ST_IDLE;
      byte_cnt_d = '0;
      word_cnt_d = '0;
      nwords_d   = '0;
      idle_d     = '0;
      word_sr_d  = '0;
      frame_sr_d = '0;
    end
  end

  always_comb begin
    busy         = (state_q == ST_ASM);
    word_cnt     = word_cnt_q;
    frame_data   = frame_data_q;
    frame_nwords = frame_nwords_q;
    frame_valid  = frame_valid_q;
    overflow     = overflow_q;
    timeout_err  = timeout_q;
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench for uart_frame_assembler: directed scenarios plus random
// traffic, compared every cycle against a byte-queue reference model.
module tb_uart_frame_assembler;

  localparam int WORD_W      = 32;
  localparam int MAX_WORDS   = 4;
  localparam int TIMEOUT_CYC = 40000;
  localparam int BPW         = WORD_W / 8;
  localparam int FW          = MAX_WORDS * WORD_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sync_clr;
  logic [7:0]    rx_byte;
  logic          rx_byte_en;
  logic [3:0]    frame_words;
  logic [FW-1:0] frame_data;
  logic [3:0]    frame_nwords;
  logic          frame_valid;
  logic          frame_ready;
  logic [3:0]    word_cnt;
  logic          busy;
  logic          overflow;
  logic          timeout_err;

  uart_frame_assembler #(
    .WORD_W(WORD_W), .MAX_WORDS(MAX_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .rx_byte(rx_byte),
    .rx_byte_en(rx_byte_en), .frame_words(frame_words), .frame_data(frame_data),
    .frame_nwords(frame_nwords), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .word_cnt(word_cnt), .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int ovf_seen = 0;
  int to_seen  = 0;

  // Reference model: bytes of the partial frame, plus the held output frame.
  logic [7:0]    bq[$];
  int            n_lat;
  int            idle;
  bit            m_valid;
  logic [FW-1:0] m_data;
  int            m_nw;
  bit            exp_ovf;
  bit            exp_to;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    n_lat = 0; idle = 0; m_valid = 0; m_data = '0; m_nw = 0; exp_ovf = 0; exp_to = 0;
  endtask

  task automatic model_step();
    logic [FW-1:0] d;
    exp_ovf = 0;
    exp_to  = 0;
    if (m_valid && frame_ready) m_valid = 0;
    if (sync_clr) begin
      bq.delete();
      idle = 0;
    end else if (rx_byte_en) begin
      if (bq.size() == 0)
        n_lat = (frame_words == 0 || frame_words > MAX_WORDS) ? MAX_WORDS : int'(frame_words);
      bq.push_back(rx_byte);
      idle = 0;
      if (bq.size() == n_lat * BPW) begin
        d = '0;
        foreach (bq[i]) d = (d << 8) | FW'(bq[i]);
        if (m_valid) exp_ovf = 1;
        else begin
          m_valid = 1; m_data = d; m_nw = n_lat;
        end
        bq.delete();
      end
    end else if (bq.size() > 0) begin
      if (idle == TIMEOUT_CYC - 1) begin
        bq.delete(); idle = 0; exp_to = 1;
      end else idle++;
    end
  endtask

  task automatic check_all();
    check("frame_valid", FW'(frame_valid), FW'(m_valid));
    check("frame_data", frame_data, m_data);
    check("frame_nwords", FW'(frame_nwords), FW'(m_nw));
    check("word_cnt", FW'(word_cnt), FW'(bq.size() / BPW));
    check("busy", FW'(busy), FW'(bq.size() > 0));
    check("overflow", FW'(overflow), FW'(exp_ovf));
    check("timeout_err", FW'(timeout_err), FW'(exp_to));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    if (overflow) ovf_seen++;
    if (timeout_err) to_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_byte_en = 1'b1;
    tick();
    rx_byte_en = 1'b0;
  endtask

  task automatic send_ramp(input logic [7:0] start, input int count);
    for (int i = 0; i < count; i++) send_byte(8'(start + i));
  endtask

  task automatic drain();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  function automatic logic [FW-1:0] ramp16(input logic [7:0] start);
    logic [FW-1:0] d = '0;
    for (int i = 0; i < 16; i++) d = (d << 8) | FW'(8'(start + i));
    return d;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, FW'(frame_valid), '0);
    check({tag, "_data"}, frame_data, '0);
    check({tag, "_nwords"}, FW'(frame_nwords), '0);
    check({tag, "_wcnt"}, FW'(word_cnt), '0);
    check({tag, "_busy"}, FW'(busy), '0);
    check({tag, "_ovf"}, FW'(overflow), '0);
    check({tag, "_to"}, FW'(timeout_err), '0);
  endtask

  initial begin
    rst_n = 1'b0; sync_clr = 1'b0; rx_byte = '0; rx_byte_en = 1'b0;
    frame_words = 4'd4; frame_ready = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    #10 rst_n = 1'b1;

    // 4-word frame
    send_ramp(8'h00, 16);
    check("f4_data", frame_data, 128'h000102030405060708090A0B0C0D0E0F);
    check("f4_nwords", FW'(frame_nwords), FW'(4));
    check("f4_valid", FW'(frame_valid), FW'(1));
    drain();
    check("f4_taken", FW'(frame_valid), '0);

    // short frame; length change mid-frame is ignored
    frame_words = 4'd2;
    send_ramp(8'hA0, 3);
    frame_words = 4'd3;
    send_ramp(8'hA3, 5);
    check("short_data", frame_data, 128'h0000000000000000A0A1A2A3A4A5A6A7);
    check("short_nwords", FW'(frame_nwords), FW'(2));
    drain();

    // overflow
    frame_words = 4'd4;
    ovf_seen = 0;
    send_ramp(8'h10, 16);
    send_ramp(8'h20, 16);
    check("ovf_pulse", FW'(overflow), FW'(1));
    tick();
    check("ovf_clear", FW'(overflow), '0);
    check("ovf_held", frame_data, ramp16(8'h10));
    check("ovf_count", FW'(ovf_seen), FW'(1));

    // completion coincident with transfer
    send_ramp(8'h30, 15);
    frame_ready = 1'b1;
    send_byte(8'h3F);
    frame_ready = 1'b0;
    check("simul_valid", FW'(frame_valid), FW'(1));
    check("simul_data", frame_data, ramp16(8'h30));
    check("simul_ovf", FW'(overflow), '0);
    drain();

    // inter-byte timeout
    to_seen = 0;
    send_ramp(8'h40, 5);
    repeat (TIMEOUT_CYC) tick();
    check("to_count", FW'(to_seen), FW'(1));
    check("to_busy", FW'(busy), '0);
    check("to_wcnt", FW'(word_cnt), '0);
    check("to_valid", FW'(frame_valid), '0);
    send_ramp(8'h50, 16);
    check("to_next", frame_data, ramp16(8'h50));
    drain();

    // async reset mid-frame with a frame pending
    send_ramp(8'h60, 16);
    send_ramp(8'h70, 9);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_zero("midrst");
    rst_n = 1'b1;
    send_ramp(8'h80, 16);
    check("rst_next", frame_data, ramp16(8'h80));
    drain();

    // sync_clr with coincident byte
    send_ramp(8'h90, 6);
    sync_clr = 1'b1;
    send_byte(8'h96);
    sync_clr = 1'b0;
    check("clr_busy", FW'(busy), '0);
    check("clr_wcnt", FW'(word_cnt), '0);
    check("clr_valid", FW'(frame_valid), '0);
    send_ramp(8'hB0, 16);
    check("clr_next", frame_data, ramp16(8'hB0));
    drain();

    // random traffic, including out-of-range lengths
    for (int i = 0; i < 4000; i++) begin
      rx_byte_en = 1'($urandom_range(0, 1));
      rx_byte    = 8'($urandom);
      if ($urandom_range(0, 15) == 0) frame_words = 4'($urandom_range(0, 15));
      frame_ready = ($urandom_range(0, 3) == 0);
      sync_clr    = ($urandom_range(0, 199) == 0);
      tick();
    end
    rx_byte_en = 1'b0; sync_clr = 1'b0; frame_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 The block SHALL have these parameters:
- WORD_W, default 32, word width in bits; SHALL be a multiple of 8, range 8..64.
- MAX_WORDS, default 4, maximum words per frame; range 1..15.
- TIMEOUT_CYC, default 40000, inter-byte idle limit in clk cycles (1 ms at 40 MHz); minimum 2.
- TO_W, default 16, idle-counter width; SHALL satisfy 2^TO_W > TIMEOUT_CYC.

REQ-002 The block SHALL have these ports (BPW = WORD_W/8):
- clk  in  1  system clock, 40 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- sync_clr  in  1  synchronous abort of any partial frame.
- rx_byte  in  8  received UART byte.
- rx_byte_en  in  1  one-cycle strobe; rx_byte is valid.
- frame_words  in  4  requested words per frame.
- frame_data  out  MAX_WORDS*WORD_W  assembled frame.
- frame_nwords  out  4  number of valid words in frame_data.
- frame_valid  out  1  frame available.
- frame_ready  in  1  consumer accepts the frame.
- word_cnt  out  4  words completed in the current partial frame.
- busy  out  1  partial frame in progress.
- overflow  out  1  one-cycle pulse; a completed frame was dropped.
- timeout_err  out  1  one-cycle pulse; a partial frame was discarded on timeout.

Function
REQ-003 Byte assembly SHALL be MSB-first: word_sr <= {word_sr[WORD_W-9:0], rx_byte} on each rx_byte_en. A word SHALL complete on the BPW-th byte.
REQ-004 On word completion, the word SHALL shift into frame_sr at the LSB end: frame_sr <= {frame_sr, word}. The first word of a frame SHALL therefore end up highest.
REQ-005 frame_sr SHALL be cleared at frame start, so unused upper words of a short frame read as zero.
REQ-006 frame_words SHALL be latched on the first byte of each frame. Changes to frame_words mid-frame SHALL be ignored.
REQ-007 A latched frame_words of 0 or greater than MAX_WORDS SHALL be treated as MAX_WORDS.
REQ-008 Frame completion SHALL occur on the byte that completes word number N, where N is the latched length.
REQ-009 On frame completion, frame_data SHALL be loaded with the final frame_sr (including the word just completed) and frame_nwords SHALL be loaded with N.
REQ-010 frame_valid SHALL rise on the clock edge of frame completion: one cycle after the final rx_byte_en.
REQ-011 On frame completion, the byte count, word_cnt and busy SHALL return to 0 on the same edge.
REQ-012 busy SHALL be 1 from the first byte of a frame until completion, timeout or sync_clr.
REQ-013 The frame output SHALL follow a valid/ready handshake:
- frame_valid SHALL hold, with frame_data and frame_nwords stable, until sampled with frame_ready = 1.
- The transfer SHALL occur on a cycle where frame_valid = 1 and frame_ready = 1.
REQ-014 If a frame completes while frame_valid = 1 and frame_ready = 0:
- the new frame SHALL be dropped;
- the held frame SHALL be kept;
- overflow SHALL pulse for one cycle.
REQ-015 If a frame completes in the same cycle a transfer occurs, the new frame SHALL load, frame_valid SHALL stay 1, and no overflow SHALL be raised.
REQ-016 The idle counter SHALL:
- clear on every rx_byte_en;
- increment each cycle while busy = 1 and no byte arrives;
- hold at 0 while busy = 0.
REQ-017 When the idle counter reaches TIMEOUT_CYC - 1 and no byte arrives that cycle:
- the partial frame SHALL be discarded (all counters and shift registers cleared, busy = 0);
- timeout_err SHALL pulse for one cycle;
- frame_valid and frame_data SHALL be unaffected.
REQ-018 If rx_byte_en coincides with the timeout cycle, the byte SHALL win: no timeout, and the counter clears.
REQ-019 sync_clr SHALL discard the partial frame exactly as a timeout does, but without asserting timeout_err.
REQ-020 sync_clr SHALL take priority over a same-cycle rx_byte_en; that byte SHALL be lost.
REQ-021 sync_clr SHALL NOT clear a pending frame_valid.
REQ-022 word_cnt and the byte counter SHALL never wrap: the frame completes at N words, and the counters SHALL never exceed N-1 and BPW-1 respectively.

Reset
REQ-023 While rst_n = 0, the block SHALL asynchronously clear every output and internal register to 0: frame_data, frame_nwords, frame_valid, word_cnt, busy, overflow, timeout_err, the idle counter and both shift registers.
REQ-024 A reset asserted mid-frame or mid-handshake SHALL discard all data. After release, the first byte SHALL start a new frame.

Verification
REQ-025 The bench SHALL cover these directed scenarios (default parameters):
- 4-word frame: frame_words = 4; bytes 0x00..0x0F -> one cycle after byte 0x0F, frame_valid = 1, frame_data = 0x000102030405060708090A0B0C0D0E0F, frame_nwords = 4.
- Short frame: frame_words = 2; bytes 0xA0..0xA7 -> frame_data = 0x...0000_A0A1A2A3_A4A5A6A7 with upper 64 bits zero, frame_nwords = 2.
- Overflow: frame_ready = 0; two 4-word frames -> overflow pulses one cycle; frame_data still holds frame 1.
- Simultaneous transfer: frame_ready = 1 on the completion cycle of frame 2 -> frame 2 loads, frame_valid stays 1, overflow = 0.
- Timeout: 5 bytes, then idle 40000 cycles -> timeout_err pulses once, busy = 0, word_cnt = 0; the next 16 bytes form a correct frame.
- Reset/clear: rst_n pulsed after 9 bytes, and separately sync_clr coincident with a byte -> all outputs 0 (reset case), no frame produced, next frame correct.
